// File: rtl/lr_pkg.sv
// Shared defaults and FSM state encoding for the sample loader.
package lr_pkg;

    localparam int DEF_ELEM_WIDTH  = 14;
    localparam int DEF_NUM_SAMPLES = 3;
    localparam int DEF_MAX_VAL     = 99;

    typedef enum logic [2:0] {
        IDLE,
        GET_X,
        GET_Y,
        FULL,
        READY,
        ERROR
    } state_t;

endpackage

// File: rtl/sample_loader_rise_detect.sv
// Registered rising-edge detector; stays quiet on the first clock after reset
// so a level already high at release is not mistaken for a fresh edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q, sig_d;
    logic armed_q, armed_d;

    always_comb begin
        sig_d   = sig;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sig_q   <= sig_d;
            armed_q <= armed_d;
        end
    end

    assign rise = sig & ~sig_q & armed_q;

endmodule

// File: rtl/sample_loader.sv
// Captures NUM_SAMPLES (x, y) word pairs from a push button into a design
// matrix with a constant-1 column and a target vector for the solver stage.
module sample_loader
    import lr_pkg::*;
#(
    parameter int ELEM_WIDTH  = DEF_ELEM_WIDTH,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int MAX_VAL     = DEF_MAX_VAL
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enter,
    input  logic [ELEM_WIDTH-1:0]                 data_in,
    input  logic                                  input_done,
    output logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0]   x_data,
    output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]     y_data,
    output logic                                  error,
    output logic                                  ready,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]      sample_count
);

    localparam int                    CW        = $clog2(NUM_SAMPLES + 1);
    localparam logic [ELEM_WIDTH-1:0] MAX_W     = ELEM_WIDTH'(MAX_VAL);
    localparam logic [ELEM_WIDTH-1:0] ONE       = ELEM_WIDTH'(1);
    localparam logic [CW-1:0]         LAST_PAIR = CW'(NUM_SAMPLES - 1);

    state_t                state_q, state_d;
    logic [ELEM_WIDTH-1:0] x_q [NUM_SAMPLES];
    logic [ELEM_WIDTH-1:0] x_d [NUM_SAMPLES];
    logic [ELEM_WIDTH-1:0] y_q [NUM_SAMPLES];
    logic [ELEM_WIDTH-1:0] y_d [NUM_SAMPLES];
    logic [CW-1:0]         count_q, count_d;
    logic                  error_q, error_d;
    logic                  ready_q, ready_d;

    logic word_ev;
    logic done_ev;
    logic in_range;

    rise_detect u_enter_rd (
        .clk  (clk),
        .rst  (rst),
        .sig  (enter),
        .rise (word_ev)
    );

    rise_detect u_done_rd (
        .clk  (clk),
        .rst  (rst),
        .sig  (input_done),
        .rise (done_ev)
    );

    assign in_range = (data_in <= MAX_W);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;

        case (state_q)
            // IDLE behaves as GET_X for pair 0 since count is zero there
            IDLE, GET_X: begin
                if (done_ev || (word_ev && !in_range)) begin
                    state_d = ERROR;
                end else if (word_ev) begin
                    for (int unsigned i = 0; i < NUM_SAMPLES; i++)
                        if (CW'(i) == count_q) x_d[i] = data_in;
                    state_d = GET_Y;
                end
            end
            GET_Y: begin
                if (done_ev || (word_ev && !in_range)) begin
                    state_d = ERROR;
                end else if (word_ev) begin
                    for (int unsigned i = 0; i < NUM_SAMPLES; i++)
                        if (CW'(i) == count_q) y_d[i] = data_in;
                    count_d = count_q + 1'b1;
                    state_d = (count_q == LAST_PAIR) ? FULL : GET_X;
                end
            end
            FULL: begin
                if (word_ev)      state_d = ERROR;
                else if (done_ev) state_d = READY;
            end
            READY: begin
                if (word_ev && !in_range) begin
                    state_d = ERROR;
                end else if (word_ev) begin
                    for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
                        x_d[i] = '0;
                        y_d[i] = '0;
                    end
                    x_d[0]  = data_in;
                    count_d = '0;
                    state_d = GET_Y;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase

        error_d = (state_d == ERROR);
        ready_d = (state_d == READY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            count_q <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
            error_q <= error_d;
            ready_q <= ready_d;
        end
    end

    for (genvar g = 0; g < NUM_SAMPLES; g++) begin : g_pack
        assign x_data[(2*g)*ELEM_WIDTH   +: ELEM_WIDTH] = x_q[g];
        assign x_data[(2*g+1)*ELEM_WIDTH +: ELEM_WIDTH] = ONE;
        assign y_data[g*ELEM_WIDTH       +: ELEM_WIDTH] = y_q[g];
    end

    assign error        = error_q;
    assign ready        = ready_q;
    assign sample_count = count_q;

endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 14: bit width of every data word and matrix element.
REQ-002 SHALL have parameter NUM_SAMPLES, default 3: number of (x, y) sample pairs per load.
REQ-003 SHALL have parameter MAX_VAL, default 99: largest accepted unsigned data_in value.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-006 SHALL have port enter, input, 1 bit: level from the push button; each rising edge offers one word.
REQ-007 SHALL have port data_in, input, ELEM_WIDTH bits: unsigned word to capture.
REQ-008 SHALL have port input_done, input, 1 bit: level; its rising edge closes the load.
REQ-009 SHALL have port x_data, output, NUM_SAMPLES*2*ELEM_WIDTH bits: design matrix, row-major.
REQ-010 SHALL have port y_data, output, NUM_SAMPLES*ELEM_WIDTH bits: target vector.
REQ-011 SHALL have port error, output, 1 bit: load failed (sticky).
REQ-012 SHALL have port ready, output, 1 bit: x_data/y_data complete and stable.
REQ-013 SHALL have port sample_count, output, $clog2(NUM_SAMPLES+1) bits: number of complete pairs captured.

Function
REQ-014 SHALL run FSM states IDLE, GET_X, GET_Y, FULL, READY, ERROR.
REQ-015 SHALL detect a word event as enter=1 while registered enter_q=0, and SHALL sample data_in on that same clock edge; holding enter high yields exactly one event.
REQ-016 SHALL use the same edge detection for input_done.
REQ-017 SHALL capture words in the order x0, y0, x1, y1, ... The first word moves IDLE→GET_Y; each y word moves GET_Y→GET_X, or GET_Y→FULL when it is pair NUM_SAMPLES.
REQ-018 SHALL store x_i at x_data[(2i)*ELEM_WIDTH +: ELEM_WIDTH] and constant 1 at x_data[(2i+1)*ELEM_WIDTH +: ELEM_WIDTH]; y_i SHALL go to y_data[i*ELEM_WIDTH +: ELEM_WIDTH].
REQ-019 SHALL increment sample_count by 1 on each captured y word.
REQ-020 SHALL move FULL→READY on an input_done event; ready SHALL be 1 from the next cycle and SHALL remain 1 while in READY.
REQ-021 SHALL enter ERROR on any of these events: data_in > MAX_VAL on a word event; an input_done event in IDLE, GET_X or GET_Y; a word event in FULL.
REQ-022 SHALL give priority to the error transition when a word event and an input_done event occur in the same cycle.
REQ-023 In ERROR, SHALL hold error=1 and ready=0, and SHALL ignore all events until reset.
REQ-024 In READY, a word event SHALL start a new load: clear the x slots and y_data to 0, set sample_count to 0, capture the word as x0, go to GET_Y, and set ready=0 on the next cycle.
REQ-025 SHALL keep x_data and y_data unchanged in every state except on a capture or a restart.
REQ-026 SHALL leave a rejected word (out-of-range or overflow) uncaptured.

Reset
REQ-027 While rst=0, SHALL force state=IDLE, all x slots and y_data=0, constant slots=1, sample_count=0, error=0, ready=0, enter_q=0, input_done_q=0.
REQ-028 SHALL discard any partial load when rst is asserted mid-load; no event is detected in the first cycle after release if enter is already high.

Structure
REQ-029 SHALL place ELEM_WIDTH, NUM_SAMPLES and MAX_VAL defaults and the state enum in shared package lr_pkg.
REQ-030 SHALL use one sub-module, rise_detect (registered rising-edge detector with active-low async reset), instantiated for enter and input_done.
REQ-031 SHALL connect x_data and y_data directly to the downstream transpose stage and matrix multiplier inputs, with ready as their start.

Verification
REQ-032 Reset: drive rst=0 with enter=1 → all outputs at REQ-027 values; release rst → no capture.
REQ-033 Nominal load: words 2,3,5,6,8,9 then input_done → x_data rows (2,1),(5,1),(8,1); y_data 3,6,9; sample_count=3; ready=1 one cycle after the input_done edge; error=0.
REQ-034 Early done: words 2,3,5,6 then input_done → error=1, ready=0, sample_count=2.
REQ-035 Out-of-range and overflow: data_in=100 → error=1 with the word not stored; in a separate run, a 7th word after 6 valid words → error=1.
REQ-036 Held button, restart and reset: enter held for 10 cycles → exactly one word captured; word 4 in READY → ready=0, x0=4, y_data=0; rst=0 in GET_Y → returns to IDLE with all outputs at reset values.
